// File: rtl/dbg_hex_formatter_pkg.sv
// Shared debug-print package: ASCII constants and the formatter state encoding.
package dbg_hex_formatter_pkg;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_X  = 8'h78;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PFX0   = 3'd1;
  localparam logic [2:0] ST_PFX1   = 3'd2;
  localparam logic [2:0] ST_DIGIT  = 3'd3;
  localparam logic [2:0] ST_CR     = 3'd4;
  localparam logic [2:0] ST_LF     = 3'd5;
  localparam logic [2:0] ST_FINISH = 3'd6;

  // States in which a byte is offered to the queue.
  function automatic logic is_emitting(input logic [2:0] st);
    return (st == ST_PFX0) || (st == ST_PFX1) || (st == ST_DIGIT) ||
           (st == ST_CR)   || (st == ST_LF);
  endfunction

endpackage

// File: rtl/dbg_hex_formatter_hex_nibble_to_ascii.sv
// Maps one 4-bit nibble to its uppercase ASCII hex character.
module hex_nibble_to_ascii
  import dbg_hex_formatter_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  logic [7:0] nibble_ext;
  assign nibble_ext = {4'b0000, nibble};

  // Digits 0-9 map onto '0'..'9', 10-15 onto 'A'..'F'.
  always_comb begin
    if (nibble < 4'd10) ascii = ASCII_0 + nibble_ext;
    else                ascii = ASCII_A + (nibble_ext - 8'd10);
  end

endmodule

// File: rtl/dbg_hex_formatter.sv
// Captures a binary value on start and writes its fixed-width ASCII hex text,
// optionally prefixed by "0x" and terminated by CR/LF, into the debug queue.
module dbg_hex_formatter
  import dbg_hex_formatter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PREFIX_EN  = 1,
  parameter int NEWLINE_EN = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] value,
  input  logic                  full,
  output logic                  wr,
  output logic [7:0]            msg,
  output logic                  busy,
  output logic                  done
);

  localparam int NIBBLES = DATA_WIDTH / 4;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  if (DATA_WIDTH < 4 || (DATA_WIDTH % 4) != 0) begin : g_bad_width
    $error("dbg_hex_formatter: DATA_WIDTH must be a positive multiple of 4");
  end

  logic [2:0]            state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]      cnt;
  logic [7:0]            digit_ascii;
  logic                  emitting;

  hex_nibble_to_ascii u_nib (
    .nibble (shreg[DATA_WIDTH-1 -: 4]),
    .ascii  (digit_ascii)
  );

  // full gates the strobe combinationally so no byte is ever pushed into a full queue.
  assign emitting = is_emitting(state);
  assign wr       = emitting && !full;
  assign busy     = (state != ST_IDLE) && (state != ST_FINISH);
  assign done     = (state == ST_FINISH);

  // Byte presented to the queue; zero whenever nothing is being emitted.
  always_comb begin
    // NOTE: default assignment first so every path drives msg and no latch is inferred.
    msg = 8'h00;
    case (state)
      ST_PFX0:  msg = ASCII_0;
      ST_PFX1:  msg = ASCII_X;
      ST_DIGIT: msg = digit_ascii;
      ST_CR:    msg = ASCII_CR;
      ST_LF:    msg = ASCII_LF;
      default:  msg = 8'h00;
    endcase
  end

  // Sequencer: advances one byte per accepted write, holds while the queue is full.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state <= ST_IDLE;
      shreg <= '0;
      cnt   <= CNT_ZERO;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            shreg <= value;
            cnt   <= CNT_LAST;
            state <= (PREFIX_EN != 0) ? ST_PFX0 : ST_DIGIT;
          end
        end
        ST_PFX0: if (wr) state <= ST_PFX1;
        ST_PFX1: if (wr) state <= ST_DIGIT;
        ST_DIGIT: begin
          if (wr) begin
            shreg <= shreg << 4;
            cnt   <= cnt - CNT_ONE;
            if (cnt == CNT_ZERO) state <= (NEWLINE_EN != 0) ? ST_CR : ST_FINISH;
          end
        end
        ST_CR:     if (wr) state <= ST_LF;
        ST_LF:     if (wr) state <= ST_FINISH;
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_hex_formatter.sv
// Scoreboard bench for dbg_hex_formatter: stimulus pushes expected bytes,
// negedge monitors pop and compare on every write strobe.
module tb_dbg_hex_formatter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] value = '0;
  logic        full = 1'b0;
  logic        wr, busy, done;
  logic [7:0]  msg;

  logic        start_s = 1'b0;
  logic [7:0]  value_s = '0;
  logic        full_s  = 1'b0;
  logic        wr_s1, busy_s1, done_s1, wr_s0, busy_s0, done_s0;
  logic [7:0]  msg_s1, msg_s0;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_s1[$];
  logic [7:0] exp_s0[$];

  always #5 clk = ~clk;

  dbg_hex_formatter #(.DATA_WIDTH(32), .PREFIX_EN(1), .NEWLINE_EN(1)) dut (
    .clk(clk), .reset(rst), .start(start), .value(value), .full(full),
    .wr(wr), .msg(msg), .busy(busy), .done(done)
  );

  dbg_hex_formatter #(.DATA_WIDTH(8), .PREFIX_EN(0), .NEWLINE_EN(1)) dut_s1 (
    .clk(clk), .reset(rst), .start(start_s), .value(value_s), .full(full_s),
    .wr(wr_s1), .msg(msg_s1), .busy(busy_s1), .done(done_s1)
  );

  dbg_hex_formatter #(.DATA_WIDTH(8), .PREFIX_EN(0), .NEWLINE_EN(0)) dut_s0 (
    .clk(clk), .reset(rst), .start(start_s), .value(value_s), .full(full_s),
    .wr(wr_s0), .msg(msg_s0), .busy(busy_s0), .done(done_s0)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_main(input logic [7:0] b[$]);
    foreach (b[i]) exp_q.push_back(b[i]);
  endtask

  // Main-instance monitors: every write must match the next expected byte.
  always @(negedge clk) begin
    if (!rst && wr) begin
      if (full) check("wr_into_full", 32'(wr), 32'h0);
      if (exp_q.size() == 0) check("unexpected_wr", {24'h0, msg}, 32'hFFFF_FFFF);
      else check("msg", {24'h0, msg}, {24'h0, exp_q.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (!rst && wr_s1) begin
      if (exp_s1.size() == 0) check("s1_unexpected_wr", {24'h0, msg_s1}, 32'hFFFF_FFFF);
      else check("s1_msg", {24'h0, msg_s1}, {24'h0, exp_s1.pop_front()});
    end
    if (!rst && wr_s0) begin
      if (exp_s0.size() == 0) check("s0_unexpected_wr", {24'h0, msg_s0}, 32'hFFFF_FFFF);
      else check("s0_msg", {24'h0, msg_s0}, {24'h0, exp_s0.pop_front()});
    end
  end

  // Prints v on the main instance. full is high in cycles [full_from, full_to];
  // while held, msg must stay at hold_msg. extra_starts pulses start in cycles 4 and 13.
  task automatic print_value(input logic [31:0] v, input int full_from, input int full_to,
                             input logic [7:0] hold_msg, input int exp_done, input bit extra_starts);
    int  cyc;
    bit  seen_done;
    bit  busy_ok;
    value = v;
    start = 1'b1;
    step();
    cyc = 1;
    start = 1'b0;
    seen_done = 1'b0;
    busy_ok = 1'b1;
    while (!seen_done && cyc < 400) begin
      full = (cyc >= full_from) && (cyc <= full_to);
      start = extra_starts && (cyc == 4 || cyc == 13);
      if (extra_starts) value = 32'h1111_1111;
      #1;
      if (full) check("msg_held_while_full", {24'h0, msg}, {24'h0, hold_msg});
      if (done) begin
        seen_done = 1'b1;
        check("done_cycle", cyc, exp_done);
        check("busy_low_at_done", 32'(busy), 32'h0);
      end else if (!busy) begin
        busy_ok = 1'b0;
      end
      if (!seen_done) begin
        step();
        cyc++;
      end
    end
    if (!seen_done) check("done_timeout", 32'h0, 32'h1);
    check("busy_high_until_done", 32'(busy_ok), 32'h1);
    full = 1'b0;
    step();
    start = 1'b0;
    check("idle_done_low", 32'(done), 32'h0);
    check("idle_busy_low", 32'(busy), 32'h0);
    check("all_bytes_seen", exp_q.size(), 32'h0);
  endtask

  initial begin
    logic [7:0] b_dead[$] = '{8'h30, 8'h78, 8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
    logic [7:0] b_ones[$] = '{8'h30, 8'h78, 8'h31, 8'h31, 8'h31, 8'h31, 8'h31, 8'h31, 8'h31, 8'h31, 8'h0D, 8'h0A};
    logic [7:0] b_ten[$]  = '{8'h30, 8'h78, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h41, 8'h0D, 8'h0A};
    logic [7:0] b_part[$] = '{8'h30, 8'h78, 8'h44, 8'h45, 8'h41};
    int d1, d0;

    // Reset state.
    #2;
    check("rst_wr", 32'(wr), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_msg", {24'h0, msg}, 32'h0);
    step();
    step();
    rst = 1'b0;
    step();

    // Plain print, full never asserted.
    push_main(b_dead);
    print_value(32'hDEAD_BEEF, 1000, -1, 8'h00, 13, 1'b0);

    // Back-pressure on the first digit, cycles 3-5.
    push_main(b_dead);
    print_value(32'hDEAD_BEEF, 3, 5, 8'h44, 16, 1'b0);

    // Starts during the print and in the FINISH cycle are ignored; next IDLE start accepted.
    push_main(b_dead);
    print_value(32'hDEAD_BEEF, 1000, -1, 8'h00, 13, 1'b1);
    push_main(b_ones);
    print_value(32'h1111_1111, 1000, -1, 8'h00, 13, 1'b0);

    // full high from the first byte for 20 cycles: nothing written, busy held.
    push_main(b_dead);
    print_value(32'hDEAD_BEEF, 1, 20, 8'h30, 33, 1'b0);

    // Asynchronous reset in the middle of the digits.
    push_main(b_part);
    value = 32'hDEAD_BEEF;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    #1;
    rst = 1'b1;
    #1;
    check("abort_wr", 32'(wr), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_msg", {24'h0, msg}, 32'h0);
    step();
    check("abort_bytes_seen", exp_q.size(), 32'h0);
    rst = 1'b0;
    step();
    push_main(b_ten);
    print_value(32'h0000_000A, 1000, -1, 8'h00, 13, 1'b0);

    // Narrow instances: 8-bit, no prefix, with and without CR/LF.
    exp_s1.push_back(8'h30); exp_s1.push_back(8'h37);
    exp_s1.push_back(8'h0D); exp_s1.push_back(8'h0A);
    exp_s0.push_back(8'h30); exp_s0.push_back(8'h37);
    value_s = 8'h07;
    start_s = 1'b1;
    step();
    start_s = 1'b0;
    d1 = -1;
    d0 = -1;
    for (int c = 1; c <= 8; c++) begin
      #1;
      if (done_s1 && d1 < 0) d1 = c;
      if (done_s0 && d0 < 0) d0 = c;
      step();
    end
    check("s1_done_cycle", d1, 32'd5);
    check("s0_done_cycle", d0, 32'd3);
    check("s1_bytes_seen", exp_s1.size(), 32'h0);
    check("s0_bytes_seen", exp_s0.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dbg_hex_formatter.md
Name: dbg_hex_formatter

Overview:
Upstream feeder for the UART debug message queue. On a start strobe it captures a binary value and emits its ASCII hex text, one byte per write, into the queue's wr/msg/full interface. Output has an optional "0x" prefix and an optional CR/LF terminator. Lets any block print register/counter values over the debug UART without its own character logic.

Parameters:
DATA_WIDTH, 32, width of value; must be a multiple of 4 and at least 4; NIBBLES = DATA_WIDTH/4
PREFIX_EN, 1, 1 = emit "0x" (0x30, 0x78) before digits
NEWLINE_EN, 1, 1 = emit CR (0x0D) then LF (0x0A) after digits

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  request to print value; sampled only in IDLE
value  input  DATA_WIDTH  value to print; captured on accepted start
full  input  1  queue full flag from the debug UART queue
wr  output  1  queue write strobe, one byte per asserted cycle
msg  output  8  ASCII byte, valid when wr=1
busy  output  1  high from cycle after accepted start until done cycle
done  output  1  one-cycle pulse after last byte is written

Behaviour:
- Reset (async, immediate): state=IDLE, wr=0, msg=0x00, busy=0, done=0, captured value and nibble counter cleared. Reset mid-message aborts it; no resume or retry; partial text already queued is left as is.
- States: IDLE, PFX0 ('0'), PFX1 ('x'), DIGIT, CR, LF, FINISH.
- IDLE: start=1 at an edge -> capture value into shift register, nibble counter=NIBBLES-1, next state PFX0 if PREFIX_EN else DIGIT. start while not IDLE is ignored (no queuing).
- Emitting states (PFX0, PFX1, DIGIT, CR, LF):
  - wr is combinational: wr = emitting && !full.
  - msg is combinational from state and current top nibble; msg=0x00 outside emitting states.
  - Advance only on edges where wr=1. While full=1, state, msg and counter hold, and there is no skip and no duplicate.
- DIGIT: emits the top nibble, MSB first; 0-9 -> 0x30-0x39, A-F -> 0x41-0x46 (uppercase). Each write shifts the register left 4 and decrements the counter.
  - After the write at counter=0 -> CR if NEWLINE_EN, else FINISH.
  - Leading zeros are always printed; the field is fixed width.
- CR -> LF -> FINISH, each on its write.
- FINISH: done=1 and busy=0 for exactly one cycle, then IDLE. start in the FINISH cycle is ignored. A new start in the following IDLE cycle is accepted.
- busy=1 in every non-IDLE, non-FINISH state.
- Latency with full=0: start accepted at edge 0; bytes on cycles 1..L, where L = 2*PREFIX_EN + NIBBLES + 2*NEWLINE_EN; done on cycle L+1. Defaults give L=12.
- full is consumed combinationally, so wr never asserts into a full queue, including when full rises in the same cycle as the first byte.

Decomposition:
- Shared debug package holds ASCII constants: ASCII_0, ASCII_X, ASCII_A, ASCII_CR, ASCII_LF, and the state encoding.
- One combinational sub-module, hex_nibble_to_ascii: 4-bit in, 8-bit out. Reused by future decimal/byte dump formatters.
- DATA_WIDTH%4 != 0 is a static elaboration error.

Test Plan:
- Defaults, value=0xDEADBEEF, pulse start, full=0 -> wr high cycles 1-12 with msg 30 78 44 45 41 44 42 45 45 46 0D 0A; done pulse cycle 13; busy high cycles 1-12.
- Same value, full forced high cycles 3-5 -> wr=0 and msg=0x44 held during 3-5; byte sequence identical to the previous scenario; done at cycle 16.
- DATA_WIDTH=8, PREFIX_EN=0, value=0x07 -> bytes 30 37 0D 0A; NEWLINE_EN=0 as well -> bytes 30 37 only, done cycle 3.
- Second start (value=0x11111111) pulsed cycles 4 and 13 during the 0xDEADBEEF print -> ignored; output unchanged. Start at cycle 14 -> accepted; prints 0x11111111.
- reset asserted asynchronously mid-DIGIT (cycle 6) -> wr, busy, done drop to 0 immediately with msg=0x00; after release, a new start=0x0000000A prints 30 78 30 30 30 30 30 30 30 41 0D 0A.
- full=1 in the cycle start is accepted and held 20 cycles -> zero writes, busy stays 1; full released -> full 12-byte sequence follows.
